// File: rtl/network_sequencer.sv
// network_sequencer: steps NUM_LAYERS layer engines through IMAGE_NUM images with start/fin handshakes
module network_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int IMAGE_NUM  = 6,
  parameter int IMG_W      = 4,
  parameter int LYR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  loop_en_i,
  input  logic [NUM_LAYERS-1:0] layer_fin_i,
  output logic [NUM_LAYERS-1:0] layer_en_o,
  output logic [NUM_LAYERS-1:0] layer_start_o,
  output logic [LYR_W-1:0]      layer_idx_o,
  output logic [IMG_W-1:0]      image_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [LYR_W-1:0] LAST_L = LYR_W'(NUM_LAYERS - 1);
  localparam logic [IMG_W-1:0] LAST_I = IMG_W'(IMAGE_NUM - 1);
  state_t                state_q, state_d;
  logic [LYR_W-1:0]      layer_q, layer_d;
  logic [IMG_W-1:0]      image_q, image_d;
  logic [NUM_LAYERS-1:0] en_q, en_d, ls_q, ls_d, act;
  logic                  busy_q, done_q, done_d, err_q, err_d, kick;
  assign act = NUM_LAYERS'(1) << layer_q;
  // next state: abort overrides everything; each fin of the active layer advances layer, then image
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    image_d = image_q;
    err_d   = err_q;
    done_d  = 1'b0;
    kick    = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      layer_d = '0;
      image_d = '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        layer_d = '0;
        image_d = '0;
        err_d   = 1'b0;
        kick    = 1'b1;
      end
    end else if (state_q == RUN) begin
      err_d = err_q | (|(layer_fin_i & ~act));
      if (|(layer_fin_i & act)) begin
        if (layer_q != LAST_L) begin
          layer_d = layer_q + 1'b1;
          kick    = 1'b1;
        end else if (image_q != LAST_I || loop_en_i) begin
          layer_d = '0;
          image_d = (image_q != LAST_I) ? image_q + 1'b1 : '0;
          kick    = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end else begin
      state_d = IDLE;
    end
    en_d = (state_d == RUN) ? NUM_LAYERS'(1) << layer_d : '0;
    ls_d = kick ? en_d : '0;
  end
  // all outputs come straight from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= '0;
      image_q <= '0;
      en_q    <= '0;
      ls_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      image_q <= image_d;
      en_q    <= en_d;
      ls_q    <= ls_d;
      busy_q  <= state_d == RUN;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign layer_en_o    = en_q;
  assign layer_start_o = ls_q;
  assign layer_idx_o   = layer_q;
  assign image_idx_o   = image_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule
